// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - fighter and combat controller encodings shared across the game logic
package fighter_pkg;

    localparam int SPRITE_W = 64;

    localparam logic [3:0] FS_IDLE      = 4'd0;
    localparam logic [3:0] FS_MOVE_FWD  = 4'd1;
    localparam logic [3:0] FS_MOVE_BWD  = 4'd2;
    localparam logic [3:0] FS_CROUCH    = 4'd3;
    localparam logic [3:0] FS_JUMP      = 4'd4;
    localparam logic [3:0] FS_WINDUP    = 4'd5;
    localparam logic [3:0] FS_ACT       = 4'd6;
    localparam logic [3:0] FS_RECOVER   = 4'd7;
    localparam logic [3:0] FS_HITSTUN   = 4'd8;
    localparam logic [3:0] FS_BLOCKSTUN = 4'd9;

    localparam logic [1:0] CS_READY      = 2'd0;
    localparam logic [1:0] CS_FIGHT      = 2'd1;
    localparam logic [1:0] CS_ROUND_END  = 2'd2;
    localparam logic [1:0] CS_MATCH_OVER = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Horizontal space between P1's right edge and P2's left edge; overlap reads as zero.
    function automatic logic [10:0] clamp_gap(input logic [9:0] left_x, input logic [9:0] right_x,
                                              input int sprite_w);
        logic [10:0] raw;
        raw = {1'b0, right_x} - {1'b0, left_x} - 11'(sprite_w);
        return raw[10] ? 11'd0 : raw;
    endfunction

endpackage

// File: rtl/stun_timer.sv
// rtl/stun_timer.sv - per-player hitstun/blockstun down-counter
module stun_timer #(
    parameter int HITSTUN_F   = 16,
    parameter int BLOCKSTUN_F = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load_hit,
    input  logic load_block,
    output logic hitstun,
    output logic blockstun
);

    localparam int CNT_W = $clog2((HITSTUN_F > BLOCKSTUN_F ? HITSTUN_F : BLOCKSTUN_F) + 1);

    logic [CNT_W-1:0] count;

    // Flags drop on the same edge the counter reaches zero, so they stay high exactly the loaded count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            hitstun   <= 1'b0;
            blockstun <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            hitstun   <= 1'b0;
            blockstun <= 1'b0;
        end else if (load_hit) begin
            count     <= CNT_W'(HITSTUN_F);
            hitstun   <= 1'b1;
            blockstun <= 1'b0;
        end else if (load_block) begin
            count     <= CNT_W'(BLOCKSTUN_F);
            hitstun   <= 1'b0;
            blockstun <= 1'b1;
        end else if (count == CNT_W'(1)) begin
            count     <= '0;
            hitstun   <= 1'b0;
            blockstun <= 1'b0;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/combat_ctrl.sv
// rtl/combat_ctrl.sv - frame-rate hit/block resolution, health, rounds and match sequencing
module combat_ctrl #(
    parameter int SPRITE_W    = fighter_pkg::SPRITE_W,
    parameter int RANGE_N     = 32,
    parameter int RANGE_D     = 48,
    parameter int HITSTUN_F   = 16,
    parameter int BLOCKSTUN_F = 12,
    parameter int MAX_HP      = 3,
    parameter int READY_F     = 60,
    parameter int END_F       = 90,
    parameter int WIN_ROUNDS  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic       p1_dir,
    input  logic       p2_dir,
    input  logic [9:0] p1_x,
    input  logic [9:0] p2_x,
    output logic       p1_hitstun,
    output logic       p2_hitstun,
    output logic       p1_blockstun,
    output logic       p2_blockstun,
    output logic [2:0] p1_hp,
    output logic [2:0] p2_hp,
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
    output logic       freeze,
    output logic       round_rst,
    output logic [1:0] winner,
    output logic       match_over
);

    import fighter_pkg::*;

    localparam int FCNT_W = $clog2((READY_F > END_F ? READY_F : END_F) + 1);
    localparam logic [FCNT_W-1:0] READY_LD = FCNT_W'(READY_F);
    localparam logic [FCNT_W-1:0] END_LD   = FCNT_W'(END_F);
    localparam logic [2:0]        HP_INIT  = 3'(MAX_HP);

    logic [1:0]        state;
    logic [FCNT_W-1:0] frame_cnt;
    logic [10:0]       gap, p1_reach, p2_reach;
    logic              p1_hit_done, p2_hit_done;
    logic              p1_conn, p2_conn;
    logic              p1_load_hit, p1_load_block, p2_load_hit, p2_load_block;
    logic [2:0]        p1_hp_nxt, p2_hp_nxt;
    logic              match_won, round_restart;

    assign gap      = clamp_gap(p1_x, p2_x, SPRITE_W);
    assign p1_reach = p1_dir ? 11'(RANGE_D) : 11'(RANGE_N);
    assign p2_reach = p2_dir ? 11'(RANGE_D) : 11'(RANGE_N);

    assign p1_conn = (state == CS_FIGHT) && (p1_state == FS_ACT) && !p1_hit_done && (gap <= p1_reach);
    assign p2_conn = (state == CS_FIGHT) && (p2_state == FS_ACT) && !p2_hit_done && (gap <= p2_reach);

    // Both directions resolve independently, so a same-frame trade damages both players.
    assign p2_load_block = p1_conn && (p2_state == FS_MOVE_BWD);
    assign p2_load_hit   = p1_conn && (p2_state != FS_MOVE_BWD);
    assign p1_load_block = p2_conn && (p1_state == FS_MOVE_BWD);
    assign p1_load_hit   = p2_conn && (p1_state != FS_MOVE_BWD);

    assign p1_hp_nxt = (p1_load_hit && p1_hp != 3'd0) ? p1_hp - 3'd1 : p1_hp;
    assign p2_hp_nxt = (p2_load_hit && p2_hp != 3'd0) ? p2_hp - 3'd1 : p2_hp;

    assign match_won     = (p1_wins == 2'(WIN_ROUNDS)) || (p2_wins == 2'(WIN_ROUNDS));
    assign round_restart = (state == CS_ROUND_END) && (frame_cnt == FCNT_W'(1)) && !match_won;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CS_READY;
            frame_cnt  <= READY_LD;
            freeze     <= 1'b1;
            round_rst  <= 1'b0;
            p1_hp      <= HP_INIT;
            p2_hp      <= HP_INIT;
            p1_wins    <= 2'd0;
            p2_wins    <= 2'd0;
            winner     <= WIN_NONE;
            match_over <= 1'b0;
        end else begin
            round_rst <= 1'b0;
            case (state)
                CS_READY: begin
                    if (frame_cnt == FCNT_W'(1)) begin
                        state  <= CS_FIGHT;
                        freeze <= 1'b0;
                    end else begin
                        frame_cnt <= frame_cnt - 1'b1;
                    end
                end
                CS_FIGHT: begin
                    p1_hp <= p1_hp_nxt;
                    p2_hp <= p2_hp_nxt;
                    if (p1_hp_nxt == 3'd0 || p2_hp_nxt == 3'd0) begin
                        state     <= CS_ROUND_END;
                        frame_cnt <= END_LD;
                        freeze    <= 1'b1;
                        if (p1_hp_nxt == 3'd0 && p2_hp_nxt == 3'd0) begin
                            winner <= WIN_DRAW;
                        end else if (p1_hp_nxt == 3'd0) begin
                            winner  <= WIN_P2;
                            p2_wins <= p2_wins + 2'd1;
                        end else begin
                            winner  <= WIN_P1;
                            p1_wins <= p1_wins + 2'd1;
                        end
                    end
                end
                CS_ROUND_END: begin
                    if (frame_cnt == FCNT_W'(1)) begin
                        if (match_won) begin
                            state      <= CS_MATCH_OVER;
                            match_over <= 1'b1;
                        end else begin
                            state     <= CS_READY;
                            frame_cnt <= READY_LD;
                            round_rst <= 1'b1;
                            p1_hp     <= HP_INIT;
                            p2_hp     <= HP_INIT;
                        end
                    end else begin
                        frame_cnt <= frame_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One connect per attack: the latch only releases once the attacker leaves ACT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_hit_done <= 1'b0;
            p2_hit_done <= 1'b0;
        end else if (round_restart) begin
            p1_hit_done <= 1'b0;
            p2_hit_done <= 1'b0;
        end else begin
            p1_hit_done <= (p1_state == FS_ACT) && (p1_hit_done || p1_conn);
            p2_hit_done <= (p2_state == FS_ACT) && (p2_hit_done || p2_conn);
        end
    end

    stun_timer #(
        .HITSTUN_F  (HITSTUN_F),
        .BLOCKSTUN_F(BLOCKSTUN_F)
    ) u_p1_stun (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (round_restart),
        .load_hit  (p1_load_hit),
        .load_block(p1_load_block),
        .hitstun   (p1_hitstun),
        .blockstun (p1_blockstun)
    );

    stun_timer #(
        .HITSTUN_F  (HITSTUN_F),
        .BLOCKSTUN_F(BLOCKSTUN_F)
    ) u_p2_stun (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (round_restart),
        .load_hit  (p2_load_hit),
        .load_block(p2_load_block),
        .hitstun   (p2_hitstun),
        .blockstun (p2_blockstun)
    );

endmodule
